// File: rtl/med_pkg.sv
// med_pkg: shared types and schedule helpers for the median sequencer.
//   state_t       - sequencer states (IDLE, LOAD, SORT, DONE)
//   P / SORT_CYCLES / LATENCY - schedule sizes for the default window
//   p_of, sort_cycles_of, latency_of - the same sizes for any odd window
//   byp_of        - BYP strobe for a given (pass, cycle) pair of the schedule
package med_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SORT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int WIDTH_DEF   = 8;
  localparam int NUMBER_DEF  = 9;
  localparam int P           = (NUMBER_DEF - 1) / 2;
  localparam int SORT_CYCLES = P * NUMBER_DEF + P;
  localparam int LATENCY     = NUMBER_DEF + SORT_CYCLES;

  function automatic int p_of(input int number);
    return (number - 1) / 2;
  endfunction

  function automatic int sort_cycles_of(input int number);
    return p_of(number) * number + p_of(number);
  endfunction

  function automatic int latency_of(input int number);
    return number + sort_cycles_of(number);
  endfunction

  // Pass p compares for NUMBER-1-p cycles, then rotates p+1 cycles so the
  // p+1 largest values sit out of the next pass. Pass index P is the final
  // phase, which only compares.
  function automatic logic byp_of(input int pass, input int cyc, input int number);
    logic byp;
    if (pass >= p_of(number)) begin
      byp = 1'b0;
    end else begin
      byp = (cyc >= number - 1 - pass);
    end
    return byp;
  endfunction

endpackage

// File: rtl/med_seq_if.sv
// med_seq_if: pixel stream in, median result out.
//   DI/DSI      - pixel sample and its strobe (source -> sequencer)
//   DO/DSO/BUSY - median, one-cycle result strobe, window-in-progress flag
interface med_seq_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] DI;
  logic             DSI;
  logic [WIDTH-1:0] DO;
  logic             DSO;
  logic             BUSY;

  modport master (output DI, DSI, input DO, DSO, BUSY);
  modport slave  (input DI, DSI, output DO, DSO, BUSY);
endinterface

// File: rtl/med_seq_med.sv
// med_seq_med: compare-exchange shift datapath.
//   i_clk - clock
//   i_dsi - 1: shift i_di in at stage 0 (load)
//   i_byp - with i_dsi=0: 1 = plain rotation of all stages,
//           0 = last stage keeps max(last, next-to-last), minimum recirculates
//   i_di  - sample input
//   o_do  - last stage (holds the running maximum of a compare pass)
module med_seq_med #(
  parameter int WIDTH  = 8,
  parameter int NUMBER = 9
) (
  input  logic             i_clk,
  input  logic             i_dsi,
  input  logic             i_byp,
  input  logic [WIDTH-1:0] i_di,
  output logic [WIDTH-1:0] o_do
);

  logic [WIDTH-1:0] r_reg [NUMBER];
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] w_head;
  logic [WIDTH-1:0] w_tail;

  // Compare-exchange between the two last stages and the head/tail muxes.
  always_comb begin
    w_hi = r_reg[NUMBER-2];
    w_lo = r_reg[NUMBER-1];
    if (r_reg[NUMBER-1] >= r_reg[NUMBER-2]) begin
      w_hi = r_reg[NUMBER-1];
      w_lo = r_reg[NUMBER-2];
    end else begin
      w_hi = r_reg[NUMBER-2];
      w_lo = r_reg[NUMBER-1];
    end
    if (i_dsi) begin
      w_head = i_di;
      w_tail = r_reg[NUMBER-2];
    end else if (i_byp) begin
      w_head = r_reg[NUMBER-1];
      w_tail = r_reg[NUMBER-2];
    end else begin
      w_head = w_lo;
      w_tail = w_hi;
    end
  end

  // Shift chain; contents need no reset since a window always reloads it.
  always_ff @(posedge i_clk) begin
    r_reg[0] <= w_head;
    for (int i = 1; i < NUMBER - 1; i++) begin
      r_reg[i] <= r_reg[i-1];
    end
    r_reg[NUMBER-1] <= w_tail;
  end

  assign o_do = r_reg[NUMBER-1];

endmodule

// File: rtl/med_seq.sv
// med_seq: median of NUMBER consecutive pixels.
//   CLK  - clock, all state on rising edge
//   nRST - asynchronous active-low reset
//   bus  - med_seq_if.slave: DI/DSI in, DO/DSO/BUSY out
// Loads a burst of NUMBER samples, runs the fixed sort schedule on the
// datapath and strobes the median on DO with DSO for one cycle.
module med_seq
  import med_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUMBER = 9
) (
  input  logic         CLK,
  input  logic         nRST,
  med_seq_if.slave     bus
);

  localparam int PL = p_of(NUMBER);
  localparam int CW = $clog2(NUMBER + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [CW-1:0]    r_pass;
  logic [CW-1:0]    w_pass_nxt;
  logic             w_med_dsi;
  logic             w_med_byp;
  logic             w_dso;
  logic             w_busy;
  logic [WIDTH-1:0] w_med_do;

  // State and counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_cnt   <= {CW{1'b0}};
      r_pass  <= {CW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pass  <= w_pass_nxt;
    end
  end

  // Next-state, counters and Mealy datapath controls.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pass_nxt  = r_pass;
    w_med_dsi   = 1'b0;
    w_med_byp   = 1'b1;
    w_dso       = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      IDLE: begin
        w_med_dsi  = bus.DSI;
        w_busy     = bus.DSI;
        w_pass_nxt = {CW{1'b0}};
        if (bus.DSI) begin
          w_state_nxt = LOAD;
          w_cnt_nxt   = CW'(1);
        end else begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = {CW{1'b0}};
        end
      end
      LOAD: begin
        w_med_dsi = 1'b1;
        if (!bus.DSI) begin
          // Short burst: drop the partial window silently.
          w_state_nxt = IDLE;
          w_cnt_nxt   = {CW{1'b0}};
        end else if (r_cnt == CW'(NUMBER - 1)) begin
          w_state_nxt = SORT;
          w_cnt_nxt   = {CW{1'b0}};
          w_pass_nxt  = {CW{1'b0}};
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      SORT: begin
        w_med_dsi = 1'b0;
        w_med_byp = byp_of(int'(r_pass), int'(r_cnt), NUMBER);
        if (r_pass == CW'(PL)) begin
          // Final phase: P compare cycles leave the median in the last stage.
          if (r_cnt == CW'(PL - 1)) begin
            w_state_nxt = DONE;
            w_cnt_nxt   = {CW{1'b0}};
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end else if (r_cnt == CW'(NUMBER - 1)) begin
          w_cnt_nxt  = {CW{1'b0}};
          w_pass_nxt = r_pass + CW'(1);
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      DONE: begin
        // A sample here starts the next window back-to-back.
        w_dso      = 1'b1;
        w_med_dsi  = bus.DSI;
        w_pass_nxt = {CW{1'b0}};
        if (bus.DSI) begin
          w_state_nxt = LOAD;
          w_cnt_nxt   = CW'(1);
        end else begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = {CW{1'b0}};
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = {CW{1'b0}};
        w_pass_nxt  = {CW{1'b0}};
        w_busy      = 1'b0;
      end
    endcase
  end

  med_seq_med #(
    .WIDTH  (WIDTH),
    .NUMBER (NUMBER)
  ) u_med (
    .i_clk (CLK),
    .i_dsi (w_med_dsi),
    .i_byp (w_med_byp),
    .i_di  (bus.DI),
    .o_do  (w_med_do)
  );

  assign bus.DO   = w_med_do;
  assign bus.DSO  = w_dso;
  assign bus.BUSY = w_busy;

endmodule
